// File: rtl/ccip_cfg_pkg.sv
// Platform CCI-P configuration constants shared by AFU-side blocks.
package ccip_cfg_pkg;

  localparam int MAX_OUTSTANDING_MMIO_RD_REQS = 64;

endpackage

// File: rtl/ccip_mmio_rd_pkg.sv
// Types and helpers shared by the MMIO read responder and its request FIFO.
package ccip_mmio_rd_pkg;

  localparam logic [1:0]  LEN_4B           = 2'd0;
  localparam logic [1:0]  LEN_8B           = 2'd1;
  localparam logic [63:0] MMIO_RD_ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  len;
    logic [8:0]  tid;
  } t_mmio_rd_req;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } t_state;

  // Illegal length, or an 8B access that is not 8B aligned.
  function automatic logic is_bad_req(input t_mmio_rd_req req);
    return ((req.len != LEN_4B) && (req.len != LEN_8B)) ||
           ((req.len == LEN_8B) && req.addr[0]);
  endfunction

  function automatic logic [63:0] format_rsp_data(input logic is_8b, input logic [63:0] csr_data);
    return is_8b ? csr_data : {csr_data[31:0], csr_data[31:0]};
  endfunction

endpackage

// File: rtl/ccip_mmio_rd_fifo.sv
// Synchronous FIFO of MMIO read requests with registered full/empty/count.
module ccip_mmio_rd_fifo
  import ccip_mmio_rd_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  t_mmio_rd_req             push_data,
  input  logic                     pop,
  output t_mmio_rd_req             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ZERO_CNT  = {(AW + 1){1'b0}};
  localparam logic [AW:0]   ONE_CNT   = (AW + 1)'(1);
  localparam logic [AW-1:0] ONE_PTR   = AW'(1);

  t_mmio_rd_req  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_r;
  logic          empty_r;
  logic          do_push_s;
  logic          do_pop_s;
  logic [AW:0]   count_next_s;

  // Qualify push/pop against the current occupancy and compute the next count.
  always_comb begin
    do_push_s    = push && !full_r;
    do_pop_s     = pop && !empty_r;
    count_next_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_next_s = count_r + ONE_CNT;
      2'b01:   count_next_s = count_r - ONE_CNT;
      default: count_next_s = count_r;
    endcase
  end

  // Pointers and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= ZERO_CNT;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + ONE_PTR;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + ONE_PTR;
      count_r <= count_next_s;
      full_r  <= (count_next_s == DEPTH_CNT);
      empty_r <= (count_next_s == ZERO_CNT);
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign count = count_r;

endmodule

// File: rtl/ccip_mmio_rd_responder.sv
// Buffers host MMIO reads from CCI-P c0 Rx, serialises them onto the CSR read
// port and returns each result on c2 Tx with the original tid.
module ccip_mmio_rd_responder
  import ccip_mmio_rd_pkg::*;
#(
  parameter int MAX_OUTSTANDING = ccip_cfg_pkg::MAX_OUTSTANDING_MMIO_RD_REQS,
  parameter int TIMEOUT_CYCLES  = 512
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               rx_mmio_rd_valid,
  input  logic [15:0]                        rx_mmio_addr,
  input  logic [1:0]                         rx_mmio_len,
  input  logic [8:0]                         rx_mmio_tid,
  output logic                               csr_rd_req,
  output logic [15:0]                        csr_rd_addr,
  output logic                               csr_rd_is_8b,
  input  logic                               csr_rd_ready,
  input  logic                               csr_rd_rsp_valid,
  input  logic [63:0]                        csr_rd_data,
  output logic                               tx_mmio_rsp_valid,
  output logic [8:0]                         tx_mmio_rsp_tid,
  output logic [63:0]                        tx_mmio_rsp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_overflow,
  output logic                               err_timeout,
  output logic                               err_bad_req
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);

  t_state           state_r;
  logic [8:0]       svc_tid_r;
  logic [WD_W-1:0]  wdog_r;
  logic             csr_rd_req_r;
  logic [15:0]      csr_rd_addr_r;
  logic             csr_rd_is_8b_r;
  logic             tx_valid_r;
  logic [8:0]       tx_tid_r;
  logic [63:0]      tx_data_r;
  logic [CNT_W-1:0] outstanding_r;
  logic             err_overflow_r;
  logic             err_timeout_r;
  logic             err_bad_req_r;

  t_mmio_rd_req     push_req_s;
  t_mmio_rd_req     head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic             resp_s;
  logic             in_service_s;
  logic             accept_s;
  logic             pop_s;
  logic             head_bad_s;

  // Capacity covers buffered entries plus the one in service; a slot frees
  // on the RESP cycle, so a push landing then is still accepted.
  always_comb begin
    push_req_s   = '{addr: rx_mmio_addr, len: rx_mmio_len, tid: rx_mmio_tid};
    resp_s       = (state_r == RESP);
    in_service_s = (state_r != IDLE);
    accept_s     = rx_mmio_rd_valid && !fifo_full_s &&
                   (((fifo_count_s + CNT_W'(in_service_s)) < MAX_CNT) || resp_s);
    pop_s        = (state_r == IDLE) && !fifo_empty_s;
    head_bad_s   = is_bad_req(head_s);
  end

  ccip_mmio_rd_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept_s),
    .push_data (push_req_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Service FSM: one CSR read in flight, response registered onto c2 Tx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      svc_tid_r      <= 9'd0;
      wdog_r         <= {WD_W{1'b0}};
      csr_rd_req_r   <= 1'b0;
      csr_rd_addr_r  <= 16'd0;
      csr_rd_is_8b_r <= 1'b0;
      tx_valid_r     <= 1'b0;
      tx_tid_r       <= 9'd0;
      tx_data_r      <= 64'd0;
      err_timeout_r  <= 1'b0;
      err_bad_req_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          tx_valid_r <= 1'b0;
          if (pop_s) begin
            svc_tid_r <= head_s.tid;
            if (head_bad_s) begin
              err_bad_req_r <= 1'b1;
              tx_valid_r    <= 1'b1;
              tx_tid_r      <= head_s.tid;
              tx_data_r     <= MMIO_RD_ERR_DATA;
              state_r       <= RESP;
            end else begin
              csr_rd_req_r   <= 1'b1;
              csr_rd_addr_r  <= head_s.addr;
              csr_rd_is_8b_r <= (head_s.len == LEN_8B);
              state_r        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (csr_rd_ready) begin
            csr_rd_req_r <= 1'b0;
            wdog_r       <= {WD_W{1'b0}};
            state_r      <= WAIT;
          end
        end
        WAIT: begin
          if (csr_rd_rsp_valid) begin
            tx_valid_r <= 1'b1;
            tx_tid_r   <= svc_tid_r;
            tx_data_r  <= format_rsp_data(csr_rd_is_8b_r, csr_rd_data);
            state_r    <= RESP;
          end else if (wdog_r == WD_LAST) begin
            err_timeout_r <= 1'b1;
            tx_valid_r    <= 1'b1;
            tx_tid_r      <= svc_tid_r;
            tx_data_r     <= MMIO_RD_ERR_DATA;
            state_r       <= RESP;
          end else begin
            wdog_r <= wdog_r + WD_ONE;
          end
        end
        RESP: begin
          tx_valid_r <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          tx_valid_r   <= 1'b0;
          csr_rd_req_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  // Occupancy counter and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_r  <= {CNT_W{1'b0}};
      err_overflow_r <= 1'b0;
    end else begin
      case ({accept_s, resp_s})
        2'b10:   outstanding_r <= outstanding_r + ONE_CNT;
        2'b01:   outstanding_r <= outstanding_r - ONE_CNT;
        default: outstanding_r <= outstanding_r;
      endcase
      if (rx_mmio_rd_valid && !accept_s) err_overflow_r <= 1'b1;
    end
  end

  assign csr_rd_req        = csr_rd_req_r;
  assign csr_rd_addr       = csr_rd_addr_r;
  assign csr_rd_is_8b      = csr_rd_is_8b_r;
  assign tx_mmio_rsp_valid = tx_valid_r;
  assign tx_mmio_rsp_tid   = tx_tid_r;
  assign tx_mmio_rsp_data  = tx_data_r;
  assign outstanding       = outstanding_r;
  assign err_overflow      = err_overflow_r;
  assign err_timeout       = err_timeout_r;
  assign err_bad_req       = err_bad_req_r;

endmodule

// File: tb/tb_ccip_mmio_rd_responder.sv
// Directed self-checking bench for ccip_mmio_rd_responder with a small CSR port model.
module tb_ccip_mmio_rd_responder;

  localparam int MAX_OUT = 64;
  localparam int TIMEOUT = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_mmio_rd_valid;
  logic [15:0] rx_mmio_addr;
  logic [1:0]  rx_mmio_len;
  logic [8:0]  rx_mmio_tid;
  logic        csr_rd_req;
  logic [15:0] csr_rd_addr;
  logic        csr_rd_is_8b;
  logic        csr_rd_ready;
  logic        csr_rd_rsp_valid;
  logic [63:0] csr_rd_data;
  logic        tx_mmio_rsp_valid;
  logic [8:0]  tx_mmio_rsp_tid;
  logic [63:0] tx_mmio_rsp_data;
  logic [6:0]  outstanding;
  logic        err_overflow;
  logic        err_timeout;
  logic        err_bad_req;

  int n_cmp  = 0;
  int n_fail = 0;

  // CSR model controls, written only by the main sequence
  logic        csr_hold      = 1'b0;
  logic        csr_mute      = 1'b0;
  logic        csr_use_fixed = 1'b0;
  int          csr_stall     = 0;
  logic [63:0] csr_fixed     = 64'd0;
  int          late_req      = 0;

  // CSR model state, written only by the model process
  int          late_done   = 0;
  int          stall_cnt   = 0;
  int          req_cycles  = 0;
  logic        rsp_pending = 1'b0;
  logic [15:0] served_addr = 16'd0;

  // Response monitor state
  int          rsp_cnt = 0;
  logic [8:0]  rsp_tid_q [$];
  logic [63:0] rsp_data_q [$];

  always #5 clk = ~clk;

  ccip_mmio_rd_responder #(
    .MAX_OUTSTANDING (MAX_OUT),
    .TIMEOUT_CYCLES  (TIMEOUT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .rx_mmio_rd_valid  (rx_mmio_rd_valid),
    .rx_mmio_addr      (rx_mmio_addr),
    .rx_mmio_len       (rx_mmio_len),
    .rx_mmio_tid       (rx_mmio_tid),
    .csr_rd_req        (csr_rd_req),
    .csr_rd_addr       (csr_rd_addr),
    .csr_rd_is_8b      (csr_rd_is_8b),
    .csr_rd_ready      (csr_rd_ready),
    .csr_rd_rsp_valid  (csr_rd_rsp_valid),
    .csr_rd_data       (csr_rd_data),
    .tx_mmio_rsp_valid (tx_mmio_rsp_valid),
    .tx_mmio_rsp_tid   (tx_mmio_rsp_tid),
    .tx_mmio_rsp_data  (tx_mmio_rsp_data),
    .outstanding       (outstanding),
    .err_overflow      (err_overflow),
    .err_timeout       (err_timeout),
    .err_bad_req       (err_bad_req)
  );

  function automatic logic [63:0] csr_word(input logic [15:0] a);
    return {16'hD00D, a, 16'hBEEF, a};
  endfunction

  // CSR port model: optional hold/stall before ready, data one cycle after accept
  initial begin
    csr_rd_ready     = 1'b0;
    csr_rd_rsp_valid = 1'b0;
    csr_rd_data      = 64'd0;
    forever begin
      @(negedge clk);
      csr_rd_rsp_valid = 1'b0;
      if (rsp_pending) begin
        csr_rd_rsp_valid = 1'b1;
        csr_rd_data      = csr_use_fixed ? csr_fixed : csr_word(served_addr);
        rsp_pending      = 1'b0;
      end else if (late_done != late_req) begin
        csr_rd_rsp_valid = 1'b1;
        csr_rd_data      = 64'h0BAD_0BAD_0BAD_0BAD;
        late_done        = late_req;
      end
      csr_rd_ready = 1'b0;
      if (csr_rd_req === 1'b1) req_cycles++;
      if (csr_rd_req === 1'b1 && !csr_hold) begin
        if (stall_cnt < csr_stall) begin
          stall_cnt++;
        end else begin
          csr_rd_ready = 1'b1;
          stall_cnt    = 0;
          served_addr  = csr_rd_addr;
          rsp_pending  = !csr_mute;
        end
      end
    end
  end

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (tx_mmio_rsp_valid === 1'b1) begin
        rsp_cnt++;
        rsp_tid_q.push_back(tx_mmio_rsp_tid);
        rsp_data_q.push_back(tx_mmio_rsp_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at time %0t", $time);
    $fatal(1, "bench did not complete");
  end

  task automatic do_read(input logic [15:0] a, input logic [1:0] l, input logic [8:0] t,
                         input int budget, output int lat, output logic [8:0] tid_o,
                         output logic [63:0] data_o);
    lat    = -1;
    tid_o  = 9'd0;
    data_o = 64'd0;
    @(negedge clk);
    rx_mmio_rd_valid = 1'b1;
    rx_mmio_addr     = a;
    rx_mmio_len      = l;
    rx_mmio_tid      = t;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      rx_mmio_rd_valid = 1'b0;
      if (tx_mmio_rsp_valid === 1'b1) begin
        lat    = k;
        tid_o  = tx_mmio_rsp_tid;
        data_o = tx_mmio_rsp_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_mmio_rd_valid = 1'b0;
    rx_mmio_addr = 16'd0;
    rx_mmio_len  = 2'd0;
    rx_mmio_tid  = 9'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({csr_rd_req, csr_rd_is_8b, tx_mmio_rsp_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000", {csr_rd_req, csr_rd_is_8b, tx_mmio_rsp_valid});
    end
    n_cmp++;
    if ({csr_rd_addr, tx_mmio_rsp_tid, tx_mmio_rsp_data} !== 89'd0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h tid %h data %h expected all 0", csr_rd_addr, tx_mmio_rsp_tid, tx_mmio_rsp_data);
    end
    n_cmp++;
    if ({outstanding, err_overflow, err_timeout, err_bad_req} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_status: outstanding %0d errs %b expected 0 000", outstanding, {err_overflow, err_timeout, err_bad_req});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({tx_mmio_rsp_valid, csr_rd_req, outstanding} !== 9'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b expected 0", {tx_mmio_rsp_valid, csr_rd_req, outstanding});
    end
  endtask

  task automatic test_single_8b();
    int lat;
    logic [8:0] t;
    logic [63:0] d;
    csr_use_fixed = 1'b1;
    csr_fixed     = 64'h1122_3344_5566_7788;
    csr_stall     = 0;
    do_read(16'h0010, 2'd1, 9'h005, 12, lat, t, d);
    n_cmp++;
    if (lat !== 4) begin n_fail++; $display("FAIL rd8_latency: got %0d expected 4", lat); end
    n_cmp++;
    if (t !== 9'h005) begin n_fail++; $display("FAIL rd8_tid: got %h expected 005", t); end
    n_cmp++;
    if (d !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL rd8_data: got %h expected 1122334455667788", d); end
    n_cmp++;
    if (served_addr !== 16'h0010) begin n_fail++; $display("FAIL rd8_csr_addr: got %h expected 0010", served_addr); end
    @(negedge clk);
    n_cmp++;
    if (outstanding !== 7'd0) begin n_fail++; $display("FAIL rd8_outstanding: got %0d expected 0", outstanding); end
  endtask

  task automatic test_single_4b();
    int lat;
    logic [8:0] t;
    logic [63:0] d;
    csr_use_fixed = 1'b1;
    csr_fixed     = 64'hAAAA_BBBB_CCCC_DDDD;
    do_read(16'h0003, 2'd0, 9'h00A, 12, lat, t, d);
    n_cmp++;
    if (lat !== 4) begin n_fail++; $display("FAIL rd4_latency: got %0d expected 4", lat); end
    n_cmp++;
    if (t !== 9'h00A) begin n_fail++; $display("FAIL rd4_tid: got %h expected 00a", t); end
    n_cmp++;
    if (d !== 64'hCCCC_DDDD_CCCC_DDDD) begin n_fail++; $display("FAIL rd4_data: got %h expected ccccddddccccdddd", d); end
    n_cmp++;
    if ({err_overflow, err_timeout, err_bad_req} !== 3'b000) begin
      n_fail++; $display("FAIL rd4_errs: got %b expected 000", {err_overflow, err_timeout, err_bad_req});
    end
  endtask

  task automatic test_bad_req();
    int lat;
    int rq0;
    logic [8:0] t;
    logic [63:0] d;
    rq0 = req_cycles;
    do_read(16'h0011, 2'd1, 9'h01F, 12, lat, t, d);
    n_cmp++;
    if (lat !== 2) begin n_fail++; $display("FAIL bad_odd_latency: got %0d expected 2", lat); end
    n_cmp++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF || t !== 9'h01F) begin
      n_fail++; $display("FAIL bad_odd_rsp: got tid %h data %h expected 01f ffffffffffffffff", t, d);
    end
    @(negedge clk);
    n_cmp++;
    if (err_bad_req !== 1'b1) begin n_fail++; $display("FAIL bad_flag: got %b expected 1", err_bad_req); end
    do_read(16'h0004, 2'd3, 9'h020, 12, lat, t, d);
    n_cmp++;
    if (lat !== 2 || d !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL bad_len: got latency %0d data %h expected 2 ffffffffffffffff", lat, d);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (req_cycles !== rq0) begin n_fail++; $display("FAIL bad_no_csr: csr_rd_req cycles got %0d expected %0d", req_cycles, rq0); end
    n_cmp++;
    if ({outstanding, err_overflow, err_timeout} !== 9'd0) begin
      n_fail++; $display("FAIL bad_status: got %b expected 0", {outstanding, err_overflow, err_timeout});
    end
  endtask

  task automatic test_back_to_back();
    int base_cnt;
    int base_idx;
    logic [63:0] w;
    logic [63:0] exp_d;
    logic [8:0]  got_t;
    logic [63:0] got_d;
    base_cnt      = rsp_cnt;
    base_idx      = rsp_tid_q.size();
    csr_use_fixed = 1'b0;
    csr_stall     = 3;
    csr_hold      = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rx_mmio_rd_valid = 1'b1;
      rx_mmio_addr     = 16'h0100 + 16'(2 * i);
      rx_mmio_len      = (i % 2 == 0) ? 2'd1 : 2'd0;
      rx_mmio_tid      = 9'(i);
    end
    @(negedge clk);
    n_cmp++;
    if (outstanding !== 7'd64) begin n_fail++; $display("FAIL burst_peak: got %0d expected 64", outstanding); end
    n_cmp++;
    if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL burst_no_overflow: got %b expected 0", err_overflow); end
    rx_mmio_addr = 16'h0200;
    rx_mmio_len  = 2'd1;
    rx_mmio_tid  = 9'd64;
    @(negedge clk);
    rx_mmio_rd_valid = 1'b0;
    n_cmp++;
    if (err_overflow !== 1'b1 || outstanding !== 7'd64) begin
      n_fail++; $display("FAIL overflow: got flag %b outstanding %0d expected 1 64", err_overflow, outstanding);
    end
    csr_hold = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (rsp_cnt >= base_cnt + 64) break;
    end
    repeat (30) @(negedge clk);
    n_cmp++;
    if (rsp_cnt - base_cnt !== 64) begin n_fail++; $display("FAIL burst_count: got %0d responses expected 64", rsp_cnt - base_cnt); end
    for (int i = 0; i < 64; i++) begin
      w     = csr_word(16'h0100 + 16'(2 * i));
      exp_d = (i % 2 == 0) ? w : {w[31:0], w[31:0]};
      got_t = (base_idx + i < rsp_tid_q.size()) ? rsp_tid_q[base_idx + i] : 9'h1FF;
      got_d = (base_idx + i < rsp_data_q.size()) ? rsp_data_q[base_idx + i] : 64'd0;
      n_cmp++;
      if (got_t !== 9'(i)) begin n_fail++; $display("FAIL burst_tid[%0d]: got %h expected %h", i, got_t, 9'(i)); end
      n_cmp++;
      if (got_d !== exp_d) begin n_fail++; $display("FAIL burst_data[%0d]: got %h expected %h", i, got_d, exp_d); end
    end
    n_cmp++;
    if (outstanding !== 7'd0) begin n_fail++; $display("FAIL burst_drain: got %0d expected 0", outstanding); end
    csr_stall = 0;
  endtask

  task automatic test_timeout();
    int n;
    int c0;
    int lat;
    logic found;
    logic [8:0]  t;
    logic [63:0] d;
    csr_use_fixed = 1'b1;
    csr_fixed     = 64'h5555_6666_7777_8888;
    csr_mute      = 1'b1;
    found         = 1'b0;
    @(negedge clk);
    rx_mmio_rd_valid = 1'b1;
    rx_mmio_addr     = 16'h0020;
    rx_mmio_len      = 2'd1;
    rx_mmio_tid      = 9'h033;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rx_mmio_rd_valid = 1'b0;
      if (csr_rd_req === 1'b1) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL to_issue: csr_rd_req seen %b expected 1", found); end
    // n counts clock edges starting with the edge that accepts the CSR request
    n = 0;
    t = 9'd0;
    d = 64'd0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (tx_mmio_rsp_valid === 1'b1) begin t = tx_mmio_rsp_tid; d = tx_mmio_rsp_data; break; end
    end
    n_cmp++;
    if (n !== TIMEOUT + 1) begin n_fail++; $display("FAIL to_latency: got %0d expected %0d", n, TIMEOUT + 1); end
    n_cmp++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF || t !== 9'h033) begin
      n_fail++; $display("FAIL to_rsp: got tid %h data %h expected 033 ffffffffffffffff", t, d);
    end
    n_cmp++;
    if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b expected 1", err_timeout); end
    c0 = rsp_cnt;
    late_req++;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (rsp_cnt !== c0 || outstanding !== 7'd0) begin
      n_fail++; $display("FAIL late_ignored: got %0d extra responses outstanding %0d expected 0 0", rsp_cnt - c0, outstanding);
    end
    csr_mute  = 1'b0;
    csr_fixed = 64'h0123_4567_89AB_CDEF;
    do_read(16'h0040, 2'd1, 9'h044, 12, lat, t, d);
    n_cmp++;
    if (lat !== 4 || d !== 64'h0123_4567_89AB_CDEF || t !== 9'h044) begin
      n_fail++; $display("FAIL after_late: got latency %0d tid %h data %h expected 4 044 0123456789abcdef", lat, t, d);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    csr_mute = 1'b1;
    @(negedge clk);
    rx_mmio_rd_valid = 1'b1;
    rx_mmio_addr     = 16'h0050;
    rx_mmio_len      = 2'd1;
    rx_mmio_tid      = 9'h055;
    @(negedge clk);
    rx_mmio_rd_valid = 1'b0;
    repeat (10) @(negedge clk);
    c0 = rsp_cnt;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({csr_rd_req, tx_mmio_rsp_valid, outstanding, err_overflow, err_timeout, err_bad_req} !== 12'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got %b expected 0",
                         {csr_rd_req, tx_mmio_rsp_valid, outstanding, err_overflow, err_timeout, err_bad_req});
    end
    n_cmp++;
    if ({tx_mmio_rsp_tid, tx_mmio_rsp_data, csr_rd_addr} !== 89'd0) begin
      n_fail++; $display("FAIL midreset_data: tid %h data %h addr %h expected 0", tx_mmio_rsp_tid, tx_mmio_rsp_data, csr_rd_addr);
    end
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    csr_mute = 1'b0;
    repeat (600) @(negedge clk);
    n_cmp++;
    if (rsp_cnt !== c0 || outstanding !== 7'd0 || err_timeout !== 1'b0) begin
      n_fail++; $display("FAIL midreset_discard: got %0d responses outstanding %0d timeout %b expected 0 0 0",
                         rsp_cnt - c0, outstanding, err_timeout);
    end
  endtask

  initial begin
    test_reset();
    test_single_8b();
    test_single_4b();
    test_bad_req();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ccip_mmio_rd_responder.md
# ccip_mmio_rd_responder

AFU-side responder for host MMIO reads arriving on CCI-P c0 Rx. It buffers up to MAX_OUTSTANDING host read requests and serialises them onto a local CSR read port. It then returns each result on c2 Tx as an MMIO read response carrying the original tid. It sits between the platform CCI-P edge registers and the AFU CSR file, and is sized from the platform MMIO read depth published in `ccip_cfg_pkg`.

## Interface
- MAX_OUTSTANDING, default `ccip_cfg_pkg::MAX_OUTSTANDING_MMIO_RD_REQS` (64): request buffer depth; power of two.
- TIMEOUT_CYCLES, default 512: CSR response watchdog limit.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rx_mmio_rd_valid  in  1  host MMIO read request; no backpressure.
- rx_mmio_addr  in  16  4-byte word address.
- rx_mmio_len  in  2  0 = 4B, 1 = 8B; values 2 and 3 are illegal.
- rx_mmio_tid  in  9  transaction id.
- csr_rd_req  out  1  CSR read request valid.
- csr_rd_addr  out  16  CSR word address.
- csr_rd_is_8b  out  1  asserted for an 8B read.
- csr_rd_ready  in  1  CSR port accepts the request this cycle.
- csr_rd_rsp_valid  in  1  CSR read data valid.
- csr_rd_data  in  64  CSR read data.
- tx_mmio_rsp_valid  out  1  c2 MMIO read response valid.
- tx_mmio_rsp_tid  out  9  echoed tid.
- tx_mmio_rsp_data  out  64  response data.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  requests buffered plus the one in service.
- err_overflow  out  1  sticky; a request arrived while the buffer was full.
- err_timeout  out  1  sticky; the CSR watchdog expired.
- err_bad_req  out  1  sticky; illegal length, or 8B read at an odd address.

## Operation
- Request FIFO stores {addr, len, tid} and writes in the same cycle as rx_mmio_rd_valid.
- Full FIFO:
  - the request is dropped and err_overflow is set;
  - no response is generated for it.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head into the service register and go to ISSUE.
  - ISSUE: drive csr_rd_req with the service register fields. When csr_rd_ready=1, go to WAIT and clear the watchdog.
  - WAIT: count the watchdog each cycle.
    - On csr_rd_rsp_valid, capture the data and go to RESP.
    - If the watchdog reaches TIMEOUT_CYCLES-1 with no response, capture 64'hFFFF_FFFF_FFFF_FFFF, set err_timeout and go to RESP.
  - RESP: pulse tx_mmio_rsp_valid for one cycle with the service tid, then return to IDLE.
- A late csr_rd_rsp_valid in any state other than WAIT is ignored.
- Bad requests:
  - the CSR port is bypassed and the FSM goes IDLE -> RESP directly with data all-ones;
  - err_bad_req is set.
- 4B response data is {csr_rd_data[31:0], csr_rd_data[31:0]}. 8B response data is csr_rd_data unchanged.
- Responses leave in request-arrival order. One CSR read is in flight at a time.
- outstanding:
  - increments on an accepted push;
  - decrements on the RESP cycle;
  - is unchanged when a push and a RESP occur in the same cycle.
- Error flags clear only on reset.

## Timing
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, watchdog 0.
- Reset mid-transaction discards all buffered and in-service requests; no response is emitted for them.
- All outputs are driven from registers; there is no combinational path from any input to any output.
- Minimum latency from rx_mmio_rd_valid to tx_mmio_rsp_valid:
  - 4 cycles with a zero-wait CSR port (push, pop/IDLE, ISSUE with ready, response in the next cycle, RESP);
  - 2 cycles for a bad request.
- Sustained throughput is one response per 4 cycles; the host limit on MMIO reads keeps the FIFO from overflowing in legal use.
- A push into an empty FIFO and the pop of that entry never occur in the same cycle; the pop sees the entry one cycle later.

## Structure
- Shared package `ccip_mmio_rd_pkg`:
  - t_mmio_rd_req struct {addr[15:0], len[1:0], tid[8:0]};
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - constant MMIO_RD_ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF.
- Sub-module: `ccip_mmio_rd_fifo`, a registered-output synchronous FIFO of t_mmio_rd_req with full, empty and count outputs.

## Test plan
- Single 8B read: addr 0x0010, tid 0x05, CSR returns 0x1122334455667788 with zero wait -> response 4 cycles later, tid 0x05, same data; outstanding returns to 0.
- Single 4B read: addr 0x0003, CSR returns 0xAAAABBBB_CCCCDDDD -> response data 0xCCCCDDDD_CCCCDDDD.
- Burst of 64 back-to-back reads, tids 0..63, with csr_rd_ready stalled 3 cycles per request -> 64 responses in tid order; err_overflow stays 0; outstanding peaks at 64.
- A 65th read while full -> err_overflow=1; only 64 responses are produced.
- CSR never responds -> after TIMEOUT_CYCLES in WAIT, response data all-ones and err_timeout=1; a late csr_rd_rsp_valid is ignored.
- 8B read at addr 0x0011 -> response all-ones 2 cycles after arrival and err_bad_req=1; csr_rd_req is never asserted. Reset asserted while in WAIT -> all outputs 0 and no response.
